// File: rtl/core_run_ctrl.sv
// core_run_ctrl: run-control / watchdog for a single processor core.
// Holds the core in reset for RESET_CYCLES cycles, then runs it under a
// MAX_CYCLES budget until halt or timeout. It also counts run cycles and
// rising edges of the core's zero flag.
module core_run_ctrl #(
    parameter int unsigned RESET_CYCLES = 2,
    parameter int unsigned MAX_CYCLES   = 7,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned ZC_W         = 8,
    parameter int unsigned AUTO_START   = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             core_zero,
    input  logic             core_halt,
    output logic             core_reset,
    output logic             running,
    output logic             done,
    output logic             timed_out,
    output logic [CNT_W-1:0] cycle_count,
    output logic [ZC_W-1:0]  zero_count
);

    localparam int unsigned     HW        = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HW-1:0]   HOLD_LAST = (RESET_CYCLES > 0) ? HW'(RESET_CYCLES - 1) : '0;
    localparam logic [CNT_W:0]  MAX_EXT   = (CNT_W + 1)'(MAX_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_RUN,
        S_DONE,
        S_TIMEOUT
    } state_e;

    state_e             state_q, state_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [CNT_W-1:0]   cyc_q, cyc_d;
    logic [ZC_W-1:0]    zc_q, zc_d;
    logic               zprev_q, zprev_d;
    logic               core_reset_q, running_q, done_q, timed_out_q;
    logic               restart;

    // Next-state and counter update for the current registered state.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cyc_d   = cyc_q;
        zc_d    = zc_q;
        zprev_d = zprev_q;
        restart = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if ((AUTO_START != 0) || start) restart = 1'b1;
            end
            S_HOLD: begin
                if (hold_q == HOLD_LAST) state_d = S_RUN;
                else                     hold_d  = hold_q + 1'b1;
            end
            S_RUN: begin
                if (start) begin
                    restart = 1'b1;
                end else begin
                    if (!(&cyc_q)) cyc_d = cyc_q + 1'b1;
                    if (core_zero && !zprev_q && !(&zc_q)) zc_d = zc_q + 1'b1;
                    zprev_d = core_zero;
                    // Halt wins over an expiring budget on the same edge.
                    if (core_halt)
                        state_d = S_DONE;
                    else if ((MAX_CYCLES != 0) && (({1'b0, cyc_q} + 1'b1) == MAX_EXT))
                        state_d = S_TIMEOUT;
                end
            end
            S_DONE, S_TIMEOUT: begin
                if (start) restart = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (restart) begin
            cyc_d   = '0;
            zc_d    = '0;
            zprev_d = 1'b0;
            hold_d  = '0;
            state_d = (RESET_CYCLES == 0) ? S_RUN : S_HOLD;
        end
    end

    // State, counters and outputs; outputs are decoded from the next state so
    // they come straight from flops.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            hold_q       <= '0;
            cyc_q        <= '0;
            zc_q         <= '0;
            zprev_q      <= 1'b0;
            core_reset_q <= 1'b1;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            timed_out_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            cyc_q        <= cyc_d;
            zc_q         <= zc_d;
            zprev_q      <= zprev_d;
            core_reset_q <= (state_d != S_RUN);
            running_q    <= (state_d == S_RUN);
            done_q       <= (state_d == S_DONE) || (state_d == S_TIMEOUT);
            timed_out_q  <= (state_d == S_TIMEOUT);
        end
    end

    assign core_reset  = core_reset_q;
    assign running     = running_q;
    assign done        = done_q;
    assign timed_out   = timed_out_q;
    assign cycle_count = cyc_q;
    assign zero_count  = zc_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: three parameterisations share one stimulus stream
// and are compared every edge against a phase/counter model.
module tb_core_run_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic core_zero = 1'b0;
    logic core_halt = 1'b0;

    always #5 clock = ~clock;

    // Instance parameters: 0 = defaults, 1 = narrow counters / no budget /
    // no hold, 2 = manual start with short hold and budget.
    int P_RC  [3] = '{2, 0, 1};
    int P_MAX [3] = '{7, 0, 5};
    int P_CW  [3] = '{16, 3, 16};
    int P_ZW  [3] = '{8, 2, 8};
    int P_AUTO[3] = '{1, 1, 0};

    logic        cr0, run0, dn0, to0;
    logic [15:0] cc0;
    logic [7:0]  zc0;
    logic        cr1, run1, dn1, to1;
    logic [2:0]  cc1;
    logic [1:0]  zc1;
    logic        cr2, run2, dn2, to2;
    logic [15:0] cc2;
    logic [7:0]  zc2;

    core_run_ctrl u_dut0 (
        .clock(clock), .reset(reset), .start(start), .core_zero(core_zero),
        .core_halt(core_halt), .core_reset(cr0), .running(run0), .done(dn0),
        .timed_out(to0), .cycle_count(cc0), .zero_count(zc0));

    core_run_ctrl #(.RESET_CYCLES(0), .MAX_CYCLES(0), .CNT_W(3), .ZC_W(2), .AUTO_START(1)) u_dut1 (
        .clock(clock), .reset(reset), .start(start), .core_zero(core_zero),
        .core_halt(core_halt), .core_reset(cr1), .running(run1), .done(dn1),
        .timed_out(to1), .cycle_count(cc1), .zero_count(zc1));

    core_run_ctrl #(.RESET_CYCLES(1), .MAX_CYCLES(5), .CNT_W(16), .ZC_W(8), .AUTO_START(0)) u_dut2 (
        .clock(clock), .reset(reset), .start(start), .core_zero(core_zero),
        .core_halt(core_halt), .core_reset(cr2), .running(run2), .done(dn2),
        .timed_out(to2), .cycle_count(cc2), .zero_count(zc2));

    logic [31:0] o_cr[3], o_run[3], o_dn[3], o_to[3], o_cc[3], o_zc[3];
    assign o_cr[0] = 32'(cr0);  assign o_run[0] = 32'(run0); assign o_dn[0] = 32'(dn0);
    assign o_to[0] = 32'(to0);  assign o_cc[0]  = 32'(cc0);  assign o_zc[0] = 32'(zc0);
    assign o_cr[1] = 32'(cr1);  assign o_run[1] = 32'(run1); assign o_dn[1] = 32'(dn1);
    assign o_to[1] = 32'(to1);  assign o_cc[1]  = 32'(cc1);  assign o_zc[1] = 32'(zc1);
    assign o_cr[2] = 32'(cr2);  assign o_run[2] = 32'(run2); assign o_dn[2] = 32'(dn2);
    assign o_to[2] = 32'(to2);  assign o_cc[2]  = 32'(cc2);  assign o_zc[2] = 32'(zc2);

    // Reference model: phase plus plain integer counters.
    typedef enum {M_IDLE, M_HOLD, M_RUN, M_DONE, M_TO} mphase_t;
    mphase_t ph[3];
    int hold_left[3];
    int cyc[3];
    int zc[3];
    int zprev[3];

    int n_cmp = 0;
    int n_err = 0;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            ph[i] = M_IDLE; hold_left[i] = 0; cyc[i] = 0; zc[i] = 0; zprev[i] = 0;
        end
    endtask

    task automatic model_restart(input int i);
        cyc[i] = 0; zc[i] = 0; zprev[i] = 0;
        if (P_RC[i] == 0) ph[i] = M_RUN;
        else begin ph[i] = M_HOLD; hold_left[i] = P_RC[i]; end
    endtask

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            int lim_c, lim_z;
            lim_c = (1 << P_CW[i]) - 1;
            lim_z = (1 << P_ZW[i]) - 1;
            case (ph[i])
                M_IDLE: if (P_AUTO[i] != 0 || start) model_restart(i);
                M_HOLD: begin
                    hold_left[i] = hold_left[i] - 1;
                    if (hold_left[i] == 0) ph[i] = M_RUN;
                end
                M_RUN: begin
                    if (start) model_restart(i);
                    else begin
                        if (cyc[i] < lim_c) cyc[i] = cyc[i] + 1;
                        if (core_zero && zprev[i] == 0 && zc[i] < lim_z) zc[i] = zc[i] + 1;
                        zprev[i] = int'(core_zero);
                        if (core_halt) ph[i] = M_DONE;
                        else if (P_MAX[i] != 0 && cyc[i] == P_MAX[i]) ph[i] = M_TO;
                    end
                end
                default: if (start) model_restart(i);
            endcase
        end
    endtask

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, i, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk("core_reset", i, o_cr[i],  32'(ph[i] != M_RUN));
            chk("running",    i, o_run[i], 32'(ph[i] == M_RUN));
            chk("done",       i, o_dn[i],  32'(ph[i] == M_DONE || ph[i] == M_TO));
            chk("timed_out",  i, o_to[i],  32'(ph[i] == M_TO));
            chk("cycle_count",i, o_cc[i],  32'(cyc[i]));
            chk("zero_count", i, o_zc[i],  32'(zc[i]));
        end
    endtask

    // One clock edge with the given inputs; inputs change 1 time unit after the edge.
    task automatic cyc_step(input logic s, input logic z, input logic h);
        start = s; core_zero = z; core_halt = h;
        @(posedge clock);
        if (reset) model_step();
        #1;
        check_all();
    endtask

    task automatic async_reset();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clock);
        #1;
        check_all();
        reset = 1'b1;
    endtask

    initial begin
        logic zpat[7];
        zpat = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        model_reset();

        // Reset held for two clocks.
        repeat (2) @(posedge clock);
        #1;
        check_all();
        chk("rst_core_reset", 0, o_cr[0], 32'd1);
        reset = 1'b1;

        // IDLE + two HOLD edges, then RUN.
        repeat (3) cyc_step(1'b0, 1'b0, 1'b0);
        chk("run_after_hold", 0, o_run[0], 32'd1);
        chk("idle_no_autostart", 2, o_cr[2], 32'd1);

        // Budget expiry with zero pattern 0,1,1,0,1,0,0.
        for (int k = 0; k < 7; k++) cyc_step(1'b0, zpat[k], 1'b0);
        chk("to_timed_out", 0, o_to[0], 32'd1);
        chk("to_count",     0, o_cc[0], 32'd7);
        chk("zero_edges",   0, o_zc[0], 32'd2);
        repeat (10) cyc_step(1'b0, 1'b0, 1'b0);
        chk("to_sticky",    0, o_to[0], 32'd1);
        chk("sat_count",    1, o_cc[1], 32'd7);
        chk("no_budget",    1, o_dn[1], 32'd0);

        // Restart, halt on 4th RUN edge.
        cyc_step(1'b1, 1'b0, 1'b0);
        repeat (2) cyc_step(1'b0, 1'b0, 1'b0);
        repeat (3) cyc_step(1'b0, 1'b0, 1'b0);
        cyc_step(1'b0, 1'b0, 1'b1);
        chk("halt_done",  0, o_dn[0], 32'd1);
        chk("halt_to",    0, o_to[0], 32'd0);
        chk("halt_count", 0, o_cc[0], 32'd4);

        // Restart from DONE, start ignored in HOLD, then abort on 3rd RUN edge.
        cyc_step(1'b1, 1'b0, 1'b0);
        cyc_step(1'b1, 1'b0, 1'b0);
        cyc_step(1'b0, 1'b0, 1'b0);
        chk("hold_ignores_start", 0, o_run[0], 32'd1);
        repeat (2) cyc_step(1'b0, 1'b0, 1'b0);
        cyc_step(1'b1, 1'b0, 1'b0);
        chk("abort_count", 0, o_cc[0], 32'd0);
        chk("abort_reset", 0, o_cr[0], 32'd1);
        repeat (2) cyc_step(1'b0, 1'b0, 1'b0);

        // Halt coincident with budget expiry -> DONE, not TIMEOUT.
        repeat (6) cyc_step(1'b0, 1'b0, 1'b0);
        cyc_step(1'b0, 1'b0, 1'b1);
        chk("halt_budget_done", 0, o_dn[0], 32'd1);
        chk("halt_budget_to",   0, o_to[0], 32'd0);
        chk("halt_budget_cnt",  0, o_cc[0], 32'd7);

        // Asynchronous reset mid-RUN.
        cyc_step(1'b1, 1'b0, 1'b0);
        repeat (4) cyc_step(1'b0, 1'b1, 1'b0);
        async_reset();
        chk("async_running", 0, o_run[0], 32'd0);
        repeat (4) cyc_step(1'b0, 1'b0, 1'b0);
        chk("manual_idle", 2, o_run[2], 32'd0);

        // Randomised stream with occasional asynchronous resets.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 149) == 0) async_reset();
            else cyc_step($urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 11) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
